id_exe_shift_reg: RTL and testbench
===================================

Name: id_exe_shift_reg

Overview:
- ID/EXE pipeline register of the pipelined CPU; directly upstream of the EXE-stage barrel shifter and ALU.
- Captures decoded operands and controls each cycle, inserts bubbles on stall/flush, and holds while EXE is busy.
- Pre-resolves shifter inputs (data, amount, direction, arithmetic) so the shifter sees registered, stable operands.
- Counts inserted bubbles for performance debug.

Parameters:
- CNT_W, 16, width of saturating bubble counter

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- stall  in  1  load-use stall from ID; insert bubble into EXE
- flush  in  1  control-flow flush of the ID instruction; insert bubble
- ex_busy  in  1  EXE stage occupied by multi-cycle op; hold all outputs
- d_a  in  32  rs operand (forwarded)
- d_b  in  32  rt operand (forwarded)
- d_imm  in  32  extended immediate
- d_pc4  in  32  PC+4
- d_sa  in  5  instruction shamt field
- d_shift, d_right, d_arith, d_var  in  1 each  shift op, right, arithmetic, variable-amount
- d_aluc  in  4  ALU control
- d_aluimm, d_wreg, d_m2reg, d_wmem, d_jal  in  1 each  decode controls
- d_rn  in  5  destination register
- e_a, e_b, e_imm, e_pc4  out  32 each  registered operands
- e_aluc  out  4;  e_rn  out  5
- e_aluimm, e_wreg, e_m2reg, e_wmem, e_jal, e_shift  out  1 each
- e_sh_d  out  32  shifter data input
- e_sh_sa  out  5  shifter amount
- e_sh_right, e_sh_arith  out  1 each  shifter direction / arithmetic select
- e_valid  out  1  EXE holds a real instruction
- bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- resetn low (async, any time including mid-hold): all outputs 0 immediately, bubble_cnt 0. First capture is on the first rising edge after release.
- Per rising edge, priority ex_busy > (stall | flush) > load.
- ex_busy=1: every register holds. stall/flush are ignored this cycle; upstream keeps them asserted until accepted. No count.
- ex_busy=0, stall|flush=1 (bubble):
  - e_valid, e_wreg, e_m2reg, e_wmem, e_jal, e_shift, e_sh_right, e_sh_arith <= 0.
  - e_aluc, e_rn, e_sh_sa <= 0; all data outputs <= 0.
  - bubble_cnt += 1, saturating at all-ones. stall and flush together count once.
- Otherwise (load): every e_* <= corresponding d_*, e_valid <= 1. Latency exactly one cycle.
- Shifter operand resolution at load:
  - d_shift=1: e_sh_d <= d_b; e_sh_sa <= d_var ? d_a[4:0] : d_sa; e_sh_right <= d_right; e_sh_arith <= d_arith & d_right.
  - d_shift=0: e_sh_d, e_sh_sa, e_sh_right, e_sh_arith <= 0, so the shifter stays quiet.
- Variable shifts use only d_a[4:0]; upper bits are ignored (amount wraps mod 32).
- d_arith with d_right=0 is treated as a logical left shift.
- No combinational path from any input to any output.

Decomposition:
- Shared package: ALUC encodings, shift-select constants, NOP/bubble control-word constant, CNT_W default.
- One sub-module: pipe_en_reg, a parameterised-width register with async active-low clear, enable, and sync clear. It is used for the data group, the control group and the counter. Bubble = sync clear; hold = enable low.

Test Plan:
- Load SRA: d_b=0x8000_00F0, d_sa=4, d_shift=1, d_right=1, d_arith=1, d_var=0 -> next cycle e_sh_d=0x8000_00F0, e_sh_sa=4, e_sh_right=1, e_sh_arith=1, e_valid=1.
- Variable SLL: d_a=0x0000_0125, d_var=1, d_right=0, d_arith=1 -> e_sh_sa=5, e_sh_right=0, e_sh_arith=0.
- Stall one cycle with d_wreg=1, d_wmem=1 -> e_wreg=0, e_wmem=0, e_valid=0, e_sh_d=0, bubble_cnt=1; the following load captures normally.
- ex_busy=1 for 3 cycles with stall=1 and changing d_* -> all outputs frozen at the prior values and bubble_cnt unchanged; after release the stall takes effect and bubble_cnt increments once.
- Assert resetn low mid-hold (between edges) -> all outputs 0 without a clock edge; bubble_cnt=0.
- Force bubble_cnt to 0xFFFE, then apply 3 bubbles -> saturates at 0xFFFF.

Source files
------------

// File: rtl/id_exe_shift_reg_pkg.sv
// Shared definitions for the ID/EXE pipeline register.
//   - ALU control encodings driven on d_aluc / e_aluc
//   - shift direction constants
//   - control / data word layouts and the bubble (NOP) control word
//   - default width of the bubble counter
package id_exe_shift_reg_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    typedef struct packed {
        logic       valid;
        logic [3:0] aluc;
        logic [4:0] rn;
        logic       aluimm;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       jal;
        logic       shift;
        logic [4:0] sh_sa;
        logic       sh_right;
        logic       sh_arith;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [31:0] sh_d;
    } data_t;

    // A bubble is an all-zero control word; the register sync clear
    // produces exactly this value.
    localparam ctrl_t CTRL_NOP = '0;

    // Variable shifts take only the low five bits of rs (amount mod 32).
    function automatic logic [4:0] sh_amount(input logic is_var,
                                             input logic [31:0] a,
                                             input logic [4:0] sa);
        return is_var ? a[4:0] : sa;
    endfunction

endpackage

// File: rtl/id_exe_shift_reg_pipe_en_reg.sv
// Generic pipeline register with async active-low clear, enable and
// synchronous clear.
//   i_clk   - rising-edge clock
//   i_rst_n - async active-low clear
//   i_en    - load enable; low holds the current value
//   i_clr   - sync clear, takes effect only while enabled
//   i_d     - next value
//   o_q     - registered value
module pipe_en_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_q <= '0;
        else if (i_en)
            o_q <= i_clr ? '0 : i_d;
    end

endmodule

// File: rtl/id_exe_shift_reg.sv
// ID/EXE pipeline register feeding the EXE barrel shifter and ALU.
// Captures decoded operands/controls, inserts bubbles on stall/flush,
// holds while EXE is busy, and pre-resolves the shifter operands.
// Ports:
//   clock, resetn           - clock, async active-low reset
//   stall, flush, ex_busy   - pipeline control (ex_busy has priority)
//   d_*                     - decoded ID-stage operands and controls
//   e_*                     - registered EXE-stage operands and controls
//   e_sh_*                  - resolved shifter inputs (zero when not a shift)
//   e_valid                 - EXE holds a real instruction
//   bubble_cnt              - saturating count of inserted bubbles
module id_exe_shift_reg
    import id_exe_shift_reg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_busy,
    input  logic [31:0]      d_a,
    input  logic [31:0]      d_b,
    input  logic [31:0]      d_imm,
    input  logic [31:0]      d_pc4,
    input  logic [4:0]       d_sa,
    input  logic             d_shift,
    input  logic             d_right,
    input  logic             d_arith,
    input  logic             d_var,
    input  logic [3:0]       d_aluc,
    input  logic             d_aluimm,
    input  logic             d_wreg,
    input  logic             d_m2reg,
    input  logic             d_wmem,
    input  logic             d_jal,
    input  logic [4:0]       d_rn,
    output logic [31:0]      e_a,
    output logic [31:0]      e_b,
    output logic [31:0]      e_imm,
    output logic [31:0]      e_pc4,
    output logic [3:0]       e_aluc,
    output logic [4:0]       e_rn,
    output logic             e_aluimm,
    output logic             e_wreg,
    output logic             e_m2reg,
    output logic             e_wmem,
    output logic             e_jal,
    output logic             e_shift,
    output logic [31:0]      e_sh_d,
    output logic [4:0]       e_sh_sa,
    output logic             e_sh_right,
    output logic             e_sh_arith,
    output logic             e_valid,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             w_en;
    logic             w_bubble;
    logic             w_cnt_en;
    ctrl_t            w_ctrl_d, w_ctrl_q;
    data_t            w_data_d, w_data_q;
    logic [CNT_W-1:0] w_cnt_d, w_cnt_q;

    assign w_en     = ~ex_busy;
    assign w_bubble = stall | flush;

    always_comb begin
        w_data_d      = '0;
        w_data_d.a    = d_a;
        w_data_d.b    = d_b;
        w_data_d.imm  = d_imm;
        w_data_d.pc4  = d_pc4;
        w_data_d.sh_d = d_shift ? d_b : 32'd0;

        w_ctrl_d        = CTRL_NOP;
        w_ctrl_d.valid  = 1'b1;
        w_ctrl_d.aluc   = d_aluc;
        w_ctrl_d.rn     = d_rn;
        w_ctrl_d.aluimm = d_aluimm;
        w_ctrl_d.wreg   = d_wreg;
        w_ctrl_d.m2reg  = d_m2reg;
        w_ctrl_d.wmem   = d_wmem;
        w_ctrl_d.jal    = d_jal;
        w_ctrl_d.shift  = d_shift;
        // Non-shift ops leave the shifter inputs at zero so it stays quiet.
        if (d_shift) begin
            w_ctrl_d.sh_sa    = sh_amount(d_var, d_a, d_sa);
            w_ctrl_d.sh_right = d_right ? SH_RIGHT : SH_LEFT;
            // Arithmetic only matters for right shifts; left is always logical.
            w_ctrl_d.sh_arith = d_arith & d_right;
        end
    end

    pipe_en_reg #(.W($bits(data_t))) u_data (
        .i_clk(clock), .i_rst_n(resetn), .i_en(w_en), .i_clr(w_bubble),
        .i_d(w_data_d), .o_q(w_data_q)
    );

    pipe_en_reg #(.W($bits(ctrl_t))) u_ctrl (
        .i_clk(clock), .i_rst_n(resetn), .i_en(w_en), .i_clr(w_bubble),
        .i_d(w_ctrl_d), .o_q(w_ctrl_q)
    );

    // Counter advances once per accepted bubble and freezes at all-ones.
    assign w_cnt_en = w_en & w_bubble & ~(&w_cnt_q);
    assign w_cnt_d  = w_cnt_q + 1'b1;

    pipe_en_reg #(.W(CNT_W)) u_cnt (
        .i_clk(clock), .i_rst_n(resetn), .i_en(w_cnt_en), .i_clr(1'b0),
        .i_d(w_cnt_d), .o_q(w_cnt_q)
    );

    assign e_a        = w_data_q.a;
    assign e_b        = w_data_q.b;
    assign e_imm      = w_data_q.imm;
    assign e_pc4      = w_data_q.pc4;
    assign e_sh_d     = w_data_q.sh_d;
    assign e_valid    = w_ctrl_q.valid;
    assign e_aluc     = w_ctrl_q.aluc;
    assign e_rn       = w_ctrl_q.rn;
    assign e_aluimm   = w_ctrl_q.aluimm;
    assign e_wreg     = w_ctrl_q.wreg;
    assign e_m2reg    = w_ctrl_q.m2reg;
    assign e_wmem     = w_ctrl_q.wmem;
    assign e_jal      = w_ctrl_q.jal;
    assign e_shift    = w_ctrl_q.shift;
    assign e_sh_sa    = w_ctrl_q.sh_sa;
    assign e_sh_right = w_ctrl_q.sh_right;
    assign e_sh_arith = w_ctrl_q.sh_arith;
    assign bubble_cnt = w_cnt_q;

endmodule

// File: tb/tb_id_exe_shift_reg.sv
module tb_id_exe_shift_reg;
    import id_exe_shift_reg_pkg::*;

    logic clock, resetn, stall, flush, ex_busy;
    logic [31:0] d_a, d_b, d_imm, d_pc4;
    logic [4:0]  d_sa, d_rn;
    logic d_shift, d_right, d_arith, d_var;
    logic [3:0]  d_aluc;
    logic d_aluimm, d_wreg, d_m2reg, d_wmem, d_jal;
    logic [31:0] e_a, e_b, e_imm, e_pc4, e_sh_d;
    logic [3:0]  e_aluc;
    logic [4:0]  e_rn, e_sh_sa;
    logic e_aluimm, e_wreg, e_m2reg, e_wmem, e_jal, e_shift;
    logic e_sh_right, e_sh_arith, e_valid;
    logic [15:0] bubble_cnt;

    int npass = 0;
    int ntotal = 0;

    id_exe_shift_reg #(.CNT_W(16)) dut (
        .clock(clock), .resetn(resetn), .stall(stall), .flush(flush),
        .ex_busy(ex_busy), .d_a(d_a), .d_b(d_b), .d_imm(d_imm),
        .d_pc4(d_pc4), .d_sa(d_sa), .d_shift(d_shift), .d_right(d_right),
        .d_arith(d_arith), .d_var(d_var), .d_aluc(d_aluc),
        .d_aluimm(d_aluimm), .d_wreg(d_wreg), .d_m2reg(d_m2reg),
        .d_wmem(d_wmem), .d_jal(d_jal), .d_rn(d_rn), .e_a(e_a), .e_b(e_b),
        .e_imm(e_imm), .e_pc4(e_pc4), .e_aluc(e_aluc), .e_rn(e_rn),
        .e_aluimm(e_aluimm), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
        .e_wmem(e_wmem), .e_jal(e_jal), .e_shift(e_shift), .e_sh_d(e_sh_d),
        .e_sh_sa(e_sh_sa), .e_sh_right(e_sh_right), .e_sh_arith(e_sh_arith),
        .e_valid(e_valid), .bubble_cnt(bubble_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Return 1 ns after the rising edge, away from the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; ex_busy = 0;
        d_a = 0; d_b = 0; d_imm = 0; d_pc4 = 0; d_sa = 0; d_rn = 0;
        d_shift = 0; d_right = 0; d_arith = 0; d_var = 0; d_aluc = 0;
        d_aluimm = 0; d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_jal = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_inputs();
        d_a = 32'hCAFE_0001; d_wreg = 1; d_shift = 1; d_b = 32'h55;
        #1;
        ntotal++; if (e_a !== 32'h0 || e_valid !== 1'b0) $display("FAIL reset_t0 e_a=%h e_valid=%b want 0/0", e_a, e_valid); else npass++;
        ntotal++; if (bubble_cnt !== 16'h0) $display("FAIL reset_cnt got=%h want 0000", bubble_cnt); else npass++;
        tick();
        ntotal++; if (e_a !== 32'h0 || e_wreg !== 1'b0 || e_sh_d !== 32'h0) $display("FAIL reset_held e_a=%h e_wreg=%b e_sh_d=%h want 0", e_a, e_wreg, e_sh_d); else npass++;
        resetn = 1'b1;
        tick();
        ntotal++; if (e_a !== 32'hCAFE_0001 || e_valid !== 1'b1 || e_wreg !== 1'b1) $display("FAIL first_capture e_a=%h v=%b w=%b want cafe0001/1/1", e_a, e_valid, e_wreg); else npass++;
        clear_inputs();
    endtask

    task automatic test_load_sra();
        d_b = 32'h8000_00F0; d_sa = 5'd4; d_shift = 1; d_right = 1; d_arith = 1; d_var = 0;
        d_a = 32'h0000_001F; d_aluc = ALUC_SRA; d_rn = 5'd7; d_wreg = 1;
        d_imm = 32'h0000_1234; d_pc4 = 32'h0040_0008; d_jal = 1; d_m2reg = 1; d_aluimm = 1;
        tick();
        ntotal++; if (e_sh_d !== 32'h8000_00F0) $display("FAIL sra_sh_d got=%h want 800000f0", e_sh_d); else npass++;
        ntotal++; if (e_sh_sa !== 5'd4) $display("FAIL sra_sh_sa got=%0d want 4", e_sh_sa); else npass++;
        ntotal++; if (e_sh_right !== 1'b1 || e_sh_arith !== 1'b1) $display("FAIL sra_dir r=%b a=%b want 1/1", e_sh_right, e_sh_arith); else npass++;
        ntotal++; if (e_valid !== 1'b1 || e_shift !== 1'b1) $display("FAIL sra_valid v=%b s=%b want 1/1", e_valid, e_shift); else npass++;
        ntotal++; if (e_aluc !== 4'hF || e_rn !== 5'd7 || e_b !== 32'h8000_00F0) $display("FAIL sra_ctrl aluc=%h rn=%0d b=%h want f/7/800000f0", e_aluc, e_rn, e_b); else npass++;
        ntotal++; if (e_imm !== 32'h1234 || e_pc4 !== 32'h0040_0008 || e_a !== 32'h1F) $display("FAIL sra_data imm=%h pc4=%h a=%h", e_imm, e_pc4, e_a); else npass++;
        ntotal++; if (e_jal !== 1'b1 || e_m2reg !== 1'b1 || e_aluimm !== 1'b1 || e_wmem !== 1'b0) $display("FAIL sra_flags jal=%b m2r=%b ai=%b wm=%b want 1/1/1/0", e_jal, e_m2reg, e_aluimm, e_wmem); else npass++;
        // Non-shift op: shifter inputs must stay zero despite d_b/d_right.
        clear_inputs();
        d_b = 32'hFFFF_0000; d_sa = 5'd9; d_right = 1; d_arith = 1; d_aluc = ALUC_ADD;
        tick();
        ntotal++; if (e_sh_d !== 32'h0 || e_sh_sa !== 5'd0) $display("FAIL noshift_quiet sh_d=%h sa=%0d want 0/0", e_sh_d, e_sh_sa); else npass++;
        ntotal++; if (e_sh_right !== 1'b0 || e_sh_arith !== 1'b0 || e_b !== 32'hFFFF_0000) $display("FAIL noshift_dir r=%b a=%b b=%h", e_sh_right, e_sh_arith, e_b); else npass++;
        clear_inputs();
    endtask

    task automatic test_var_sll();
        d_a = 32'h0000_0125; d_b = 32'h0000_1234; d_sa = 5'd9;
        d_shift = 1; d_var = 1; d_right = 0; d_arith = 1;
        tick();
        ntotal++; if (e_sh_sa !== 5'd5) $display("FAIL var_sa got=%0d want 5", e_sh_sa); else npass++;
        ntotal++; if (e_sh_right !== 1'b0 || e_sh_arith !== 1'b0) $display("FAIL var_dir r=%b a=%b want 0/0", e_sh_right, e_sh_arith); else npass++;
        ntotal++; if (e_sh_d !== 32'h1234) $display("FAIL var_sh_d got=%h want 00001234", e_sh_d); else npass++;
        // Upper rs bits ignored: 0xFFFF_FFE3 -> amount 3.
        d_a = 32'hFFFF_FFE3; d_right = 1; d_arith = 0;
        tick();
        ntotal++; if (e_sh_sa !== 5'd3 || e_sh_right !== 1'b1 || e_sh_arith !== 1'b0) $display("FAIL var_wrap sa=%0d r=%b a=%b want 3/1/0", e_sh_sa, e_sh_right, e_sh_arith); else npass++;
        clear_inputs();
    endtask

    task automatic test_stall();
        d_a = 32'h0000_DEAD; d_wreg = 1; d_wmem = 1; d_shift = 1; d_b = 32'h77;
        stall = 1;
        tick();
        ntotal++; if (e_wreg !== 1'b0 || e_wmem !== 1'b0 || e_valid !== 1'b0) $display("FAIL stall_ctrl w=%b m=%b v=%b want 0/0/0", e_wreg, e_wmem, e_valid); else npass++;
        ntotal++; if (e_sh_d !== 32'h0 || e_a !== 32'h0 || e_shift !== 1'b0) $display("FAIL stall_data sh_d=%h a=%h s=%b want 0", e_sh_d, e_a, e_shift); else npass++;
        ntotal++; if (bubble_cnt !== 16'd1) $display("FAIL stall_cnt got=%0d want 1", bubble_cnt); else npass++;
        stall = 0;
        tick();
        ntotal++; if (e_a !== 32'hDEAD || e_valid !== 1'b1 || e_wreg !== 1'b1 || e_sh_d !== 32'h77) $display("FAIL after_stall a=%h v=%b w=%b sh_d=%h", e_a, e_valid, e_wreg, e_sh_d); else npass++;
        ntotal++; if (bubble_cnt !== 16'd1) $display("FAIL after_stall_cnt got=%0d want 1", bubble_cnt); else npass++;
        // stall+flush together counts once, flush alone counts too.
        stall = 1; flush = 1;
        tick();
        ntotal++; if (bubble_cnt !== 16'd2 || e_valid !== 1'b0) $display("FAIL both_cnt cnt=%0d v=%b want 2/0", bubble_cnt, e_valid); else npass++;
        stall = 0;
        tick();
        ntotal++; if (bubble_cnt !== 16'd3 || e_valid !== 1'b0) $display("FAIL flush_cnt cnt=%0d v=%b want 3/0", bubble_cnt, e_valid); else npass++;
        clear_inputs();
    endtask

    task automatic test_busy_hold();
        d_a = 32'h1111_1111; d_b = 32'hAB; d_sa = 5'd3; d_shift = 1; d_wreg = 1; d_rn = 5'd9;
        tick();
        ex_busy = 1; stall = 1;
        for (int i = 0; i < 3; i++) begin
            d_a = 32'h2000_0000 + i; d_b = 32'h300 + i; d_sa = 5'd17; d_rn = 5'd1;
            tick();
            ntotal++; if (e_a !== 32'h1111_1111 || e_sh_d !== 32'hAB || e_sh_sa !== 5'd3) $display("FAIL busy_data[%0d] a=%h sh_d=%h sa=%0d", i, e_a, e_sh_d, e_sh_sa); else npass++;
            ntotal++; if (e_valid !== 1'b1 || e_wreg !== 1'b1 || e_rn !== 5'd9) $display("FAIL busy_ctrl[%0d] v=%b w=%b rn=%0d", i, e_valid, e_wreg, e_rn); else npass++;
            ntotal++; if (bubble_cnt !== 16'd3) $display("FAIL busy_cnt[%0d] got=%0d want 3", i, bubble_cnt); else npass++;
        end
        ex_busy = 0;
        tick();
        ntotal++; if (e_valid !== 1'b0 || e_a !== 32'h0 || bubble_cnt !== 16'd4) $display("FAIL busy_release v=%b a=%h cnt=%0d want 0/0/4", e_valid, e_a, bubble_cnt); else npass++;
        clear_inputs();
    endtask

    task automatic test_async_reset();
        d_a = 32'h5A5A_5A5A; d_wreg = 1; d_shift = 1; d_b = 32'h99;
        tick();
        ex_busy = 1;
        tick();
        #2 resetn = 1'b0;
        #1;
        ntotal++; if (e_a !== 32'h0 || e_valid !== 1'b0 || e_wreg !== 1'b0 || e_sh_d !== 32'h0) $display("FAIL async_rst a=%h v=%b w=%b sh_d=%h want 0", e_a, e_valid, e_wreg, e_sh_d); else npass++;
        ntotal++; if (bubble_cnt !== 16'h0) $display("FAIL async_rst_cnt got=%0d want 0", bubble_cnt); else npass++;
        tick();
        resetn = 1'b1;
        clear_inputs();
    endtask

    task automatic test_saturate();
        stall = 1;
        repeat (65534) tick();
        ntotal++; if (bubble_cnt !== 16'hFFFE) $display("FAIL sat_pre got=%h want fffe", bubble_cnt); else npass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            ntotal++; if (bubble_cnt !== 16'hFFFF) $display("FAIL sat[%0d] got=%h want ffff", i, bubble_cnt); else npass++;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_sra();
        test_var_sll();
        test_stall();
        test_busy_hold();
        test_async_reset();
        test_saturate();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
